fetch_stall_ctrl: RTL and testbench

// - Consumer side of the load-use stall interface: owns the PC register and the IF/ID pipeline latch.
// - Honours pc_write / ifid_write / st from the hazard unit and drives the ID/EX bubble select.
// - Redirects the PC and flushes IF/ID on a taken branch resolved in EX.
// - Sits between instruction memory and decode in the 5-stage RISC pipeline.

---
 rtl/fetch_stall_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_ctrl.sv
// PC register and IF/ID latch honouring hazard-unit stalls and EX-stage redirects.
// Optional PERF_CNT_EN adds saturating stall/redirect counters; otherwise both read 0.
module fetch_stall_ctrl #(
    parameter int unsigned PC_W         = 16,
    parameter int unsigned INSTR_W      = 16,
    parameter int unsigned PC_STEP      = 1,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_write,
    input  logic               ifid_write,
    input  logic               st,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic               idex_bubble,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [PC_W-1:0]   PC_RST    = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0]   PC_INC    = PC_W'(PC_STEP);

    state_e             state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ifpc_q, ifpc_d;
    logic               valid_q, valid_d;
    logic               stall_edge;

    // A FLUSH edge with the counter expired behaves exactly like a RUN edge,
    // except that the state returns to RUN regardless of pc_write.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ifpc_d     = ifpc_q;
        valid_d    = valid_q;
        stall_edge = 1'b0;
        if (branch_taken) begin
            pc_d    = branch_target;
            instr_d = '0;
            valid_d = 1'b0;
            fcnt_d  = FCNT_INIT;
            state_d = ST_FLUSH;
        end else if (state_q == ST_FLUSH && fcnt_q != '0) begin
            fcnt_d = fcnt_q - 1'b1;
        end else begin
            if (pc_write) begin
                pc_d = pc_q + PC_INC;
            end
            if (ifid_write) begin
                instr_d = imem_rdata;
                ifpc_d  = pc_q;
                valid_d = 1'b1;
            end
            if (state_q == ST_FLUSH) begin
                state_d = ST_RUN;
            end else begin
                state_d    = pc_write ? ST_RUN : ST_STALL;
                stall_edge = ~pc_write;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            pc_q    <= PC_RST;
            instr_q <= '0;
            ifpc_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_edge && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_taken && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_stall_edge;
    assign unused_stall_edge = stall_edge;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign imem_addr   = pc_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc     = ifpc_q;
    assign ifid_valid  = valid_q;
    assign idex_bubble = st | ~valid_q;
    assign state       = state_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: vector table on a default instance, plus
// hand sequences on FLUSH_CYCLES=3 and RESET_PC=0xFFFF instances.
module tb_fetch_stall_ctrl;

    typedef struct {
        logic        pw, iw, st, br;
        logic [15:0] tgt;
        logic [15:0] pc, instr, ifpc;
        logic        valid, bub;
        logic [1:0]  state;
        int unsigned scnt, fcnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write, ifid_write, st, branch_taken;
    logic [15:0] branch_target;

    logic [15:0] addr_m, instr_m, ifpc_m, rdata_m, scnt_m, fcnt_m;
    logic        valid_m, bub_m;
    logic [1:0]  state_m;
    logic [15:0] addr_f, instr_f, ifpc_f, rdata_f, scnt_f, fcnt_f;
    logic        valid_f, bub_f;
    logic [1:0]  state_f;
    logic [15:0] addr_w, instr_w, ifpc_w, rdata_w, scnt_w, fcnt_w;
    logic        valid_w, bub_w;
    logic [1:0]  state_w;

    int unsigned checks = 0;
    int unsigned errors = 0;
    vec_t        tbl[18];

    always #5 clk = ~clk;

    assign rdata_m = 16'h1000 + addr_m;
    assign rdata_f = 16'h1000 + addr_f;
    assign rdata_w = 16'h1000 + addr_w;

    fetch_stall_ctrl u_main (
        .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write), .st(st),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem_rdata(rdata_m),
        .imem_addr(addr_m), .ifid_instr(instr_m), .ifid_pc(ifpc_m), .ifid_valid(valid_m),
        .idex_bubble(bub_m), .state(state_m), .stall_cnt(scnt_m), .flush_cnt(fcnt_m)
    );

    fetch_stall_ctrl #(.FLUSH_CYCLES(3)) u_f3 (
        .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write), .st(st),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem_rdata(rdata_f),
        .imem_addr(addr_f), .ifid_instr(instr_f), .ifid_pc(ifpc_f), .ifid_valid(valid_f),
        .idex_bubble(bub_f), .state(state_f), .stall_cnt(scnt_f), .flush_cnt(fcnt_f)
    );

    fetch_stall_ctrl #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write), .st(st),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem_rdata(rdata_w),
        .imem_addr(addr_w), .ifid_instr(instr_w), .ifid_pc(ifpc_w), .ifid_valid(valid_w),
        .idex_bubble(bub_w), .state(state_w), .stall_cnt(scnt_w), .flush_cnt(fcnt_w)
    );

    function automatic int unsigned cexp(input int unsigned v);
`ifdef PERF_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic vec_t mk(input logic pw, iw, s, br, input logic [15:0] tgt,
                                input logic [15:0] pc, instr, ifpc, input logic valid, bub,
                                input logic [1:0] state, input int unsigned scnt, fcnt);
        vec_t v;
        v.pw = pw; v.iw = iw; v.st = s; v.br = br; v.tgt = tgt;
        v.pc = pc; v.instr = instr; v.ifpc = ifpc; v.valid = valid; v.bub = bub;
        v.state = state; v.scnt = scnt; v.fcnt = fcnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pw, iw, s, br, input logic [15:0] tgt);
        pc_write = pw; ifid_write = iw; st = s; branch_taken = br; branch_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                pw iw st br tgt       pc       instr     ifpc    v  bub st  sc fc
        tbl[0]  = mk(1, 1, 0, 0, 16'h0,  16'h01, 16'h1000, 16'h00, 1, 0, 2'd0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 16'h0,  16'h02, 16'h1001, 16'h01, 1, 0, 2'd0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 16'h0,  16'h03, 16'h1002, 16'h02, 1, 0, 2'd0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 0, 16'h0,  16'h04, 16'h1003, 16'h03, 1, 0, 2'd0, 0, 0);
        tbl[4]  = mk(1, 1, 0, 0, 16'h0,  16'h05, 16'h1004, 16'h04, 1, 0, 2'd0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 16'h0,  16'h05, 16'h1004, 16'h04, 1, 1, 2'd1, 1, 0);
        tbl[6]  = mk(1, 1, 0, 0, 16'h0,  16'h06, 16'h1005, 16'h05, 1, 0, 2'd0, 1, 0);
        tbl[7]  = mk(1, 1, 0, 0, 16'h0,  16'h07, 16'h1006, 16'h06, 1, 0, 2'd0, 1, 0);
        tbl[8]  = mk(1, 1, 0, 0, 16'h0,  16'h08, 16'h1007, 16'h07, 1, 0, 2'd0, 1, 0);
        tbl[9]  = mk(1, 1, 0, 1, 16'h40, 16'h40, 16'h0000, 16'h07, 0, 1, 2'd2, 1, 1);
        tbl[10] = mk(1, 1, 0, 0, 16'h0,  16'h41, 16'h1040, 16'h40, 1, 0, 2'd0, 1, 1);
        tbl[11] = mk(0, 0, 1, 1, 16'h80, 16'h80, 16'h0000, 16'h40, 0, 1, 2'd2, 1, 2);
        tbl[12] = mk(1, 1, 0, 0, 16'h0,  16'h81, 16'h1080, 16'h80, 1, 0, 2'd0, 1, 2);
        tbl[13] = mk(0, 1, 0, 0, 16'h0,  16'h81, 16'h1081, 16'h81, 1, 0, 2'd1, 2, 2);
        tbl[14] = mk(1, 0, 0, 0, 16'h0,  16'h82, 16'h1081, 16'h81, 1, 0, 2'd0, 2, 2);
        tbl[15] = mk(0, 0, 1, 0, 16'h0,  16'h82, 16'h1081, 16'h81, 1, 1, 2'd1, 3, 2);
        tbl[16] = mk(0, 0, 1, 0, 16'h0,  16'h82, 16'h1081, 16'h81, 1, 1, 2'd1, 4, 2);
        tbl[17] = mk(1, 1, 0, 0, 16'h0,  16'h83, 16'h1082, 16'h82, 1, 0, 2'd0, 4, 2);

        rst = 1'b1;
        drive(0, 0, 0, 0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst pc",     addr_m,  16'h0);
        chk("rst instr",  instr_m, 16'h0);
        chk("rst ifpc",   ifpc_m,  16'h0);
        chk("rst valid",  valid_m, 1'b0);
        chk("rst bubble", bub_m,   1'b1);
        chk("rst state",  state_m, 2'd0);
        chk("rst scnt",   scnt_m,  16'h0);
        chk("rst fcnt",   fcnt_m,  16'h0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].pw, tbl[i].iw, tbl[i].st, tbl[i].br, tbl[i].tgt);
            step();
            chk($sformatf("v%0d pc", i),     addr_m,  tbl[i].pc);
            chk($sformatf("v%0d instr", i),  instr_m, tbl[i].instr);
            chk($sformatf("v%0d ifpc", i),   ifpc_m,  tbl[i].ifpc);
            chk($sformatf("v%0d valid", i),  valid_m, tbl[i].valid);
            chk($sformatf("v%0d bubble", i), bub_m,   tbl[i].bub);
            chk($sformatf("v%0d state", i),  state_m, tbl[i].state);
            chk($sformatf("v%0d scnt", i),   scnt_m,  cexp(tbl[i].scnt));
            chk($sformatf("v%0d fcnt", i),   fcnt_m,  cexp(tbl[i].fcnt));
            @(negedge clk);
        end

        // Wrap-around and three-cycle flush sequences.
        rst = 1'b1;
        drive(1, 1, 0, 0, 16'h0);
        #1;
        chk("wrap rst pc", addr_w, 16'hFFFF);
        chk("f3 rst pc",   addr_f, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("wrap pc",    addr_w,  16'h0000);
        chk("wrap ifpc",  ifpc_w,  16'hFFFF);
        chk("wrap instr", instr_w, 16'h0FFF);
        chk("wrap valid", valid_w, 1'b1);
        chk("f3 s1 pc",   addr_f,  16'h1);
        @(negedge clk);
        step();
        chk("f3 s2 pc",   addr_f,  16'h2);
        chk("f3 s2 ifpc", ifpc_f,  16'h1);
        @(negedge clk);
        drive(1, 1, 0, 1, 16'h40);
        step();
        chk("f3 br pc",    addr_f,  16'h40);
        chk("f3 br valid", valid_f, 1'b0);
        chk("f3 br state", state_f, 2'd2);
        chk("f3 br instr", instr_f, 16'h0);
        @(negedge clk);
        drive(1, 1, 0, 0, 16'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("f3 hold%0d pc", k),    addr_f,  16'h40);
            chk($sformatf("f3 hold%0d valid", k), valid_f, 1'b0);
            chk($sformatf("f3 hold%0d bub", k),   bub_f,   1'b1);
            chk($sformatf("f3 hold%0d state", k), state_f, 2'd2);
            @(negedge clk);
        end
        step();
        chk("f3 resume pc",    addr_f,  16'h41);
        chk("f3 resume valid", valid_f, 1'b1);
        chk("f3 resume instr", instr_f, 16'h1040);
        chk("f3 resume ifpc",  ifpc_f,  16'h40);
        chk("f3 resume state", state_f, 2'd0);
        @(negedge clk);
        drive(1, 1, 0, 1, 16'h20);
        step();
        chk("f3 br2 pc", addr_f, 16'h20);
        @(negedge clk);
        drive(1, 1, 0, 0, 16'h0);
        step();
        chk("f3 br2 hold state", state_f, 2'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("f3 midflush rst pc",    addr_f,  16'h0);
        chk("f3 midflush rst state", state_f, 2'd0);
        chk("f3 midflush rst valid", valid_f, 1'b0);
        chk("f3 midflush rst instr", instr_f, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("f3 post rst pc",    addr_f,  16'h1);
        chk("f3 post rst instr", instr_f, 16'h1000);
        chk("f3 post rst ifpc",  ifpc_f,  16'h0);
        chk("f3 post rst valid", valid_f, 1'b1);
        chk("f3 post rst state", state_f, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
